// File: rtl/mem_io_responder_pkg.sv
// Shared address map for the memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE       = 18'h30000;
  localparam logic [1:0]  IO_PORT_DATA  = 2'b00;
  localparam logic [2:0]  IO_PORT_CLK   = 3'h4;
  localparam logic [1:0]  IO_REGION_SEL = 2'b11;

  localparam logic [17:0] IO_DATA_ADDR = IO_BASE + 18'(IO_PORT_DATA);
  localparam logic [17:0] IO_CLK_ADDR  = IO_BASE + 18'(IO_PORT_CLK);

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_REGION_SEL;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with synchronous active-high reset; a pop frees a slot for a same-cycle push.
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next
);

  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = count == (AW + 1)'(DEPTH);
  assign empty    = count == '0;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: RAM, UART FIFOs, cycle counter and stop flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned RX_DEPTH    = 16,
  parameter int unsigned FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_done
);

  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;

  logic [7:0]     ram [2**ADDR_WIDTH];
  logic [7:0]     ram_rdata_q;
  logic [7:0]     io_rdata_q, io_rdata_d;
  logic           rd_io_q;
  logic [31:0]    cnt_q;
  logic [31:0]    snap_q;
  logic           done_q;
  logic           ibf_q;

  logic           io_sel, data_hit, clk_hit, clk_byte0;
  logic [1:0]     byte_sel;
  logic           rd, wr;
  logic           tx_push, tx_empty, tx_full;
  logic [7:0]     tx_push_data;
  logic [TCW-1:0] tx_count, tx_count_next;
  logic           rx_pop, rx_empty, rx_full;
  logic [7:0]     rx_head;
  logic [RCW-1:0] rx_count, rx_count_next;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign io_sel    = is_io(mem_a);
  assign data_hit  = mem_a[17:0] == IO_DATA_ADDR;
  assign clk_hit   = mem_a[17:2] == IO_CLK_ADDR[17:2];
  assign byte_sel  = mem_a[1:0];
  assign clk_byte0 = clk_hit && byte_sel == 2'd0;
  assign rd        = !mem_wr;
  assign wr        = mem_wr;
  assign ram_addr  = mem_a[ADDR_WIDTH-1:0];

  // Only the first stop write emits the 0x00 marker.
  assign tx_push      = wr && ((data_hit && mem_dout != 8'h00) || (clk_byte0 && !done_q));
  assign tx_push_data = data_hit ? mem_dout : 8'h00;
  assign rx_pop       = rd && data_hit;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (tx_push),
    .push_data  (tx_push_data),
    .pop        (tx_ready),
    .pop_data   (tx_data),
    .full       (tx_full),
    .empty      (tx_empty),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (rx_valid && rx_ready),
    .push_data  (rx_data),
    .pop        (rx_pop),
    .pop_data   (rx_head),
    .full       (rx_full),
    .empty      (rx_empty),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

  assign tx_valid       = !tx_empty;
  assign rx_ready       = !rx_full;
  assign io_buffer_full = ibf_q;
  assign program_done   = done_q;
  assign mem_din        = rd_io_q ? io_rdata_q : ram_rdata_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in && wr && !io_sel) ram[ram_addr] <= mem_dout;
    if (!rst_in && rd && !io_sel) ram_rdata_q <= ram[ram_addr];
  end

  // Byte 0 comes from the live counter; the upper bytes from the snapshot it loads.
  always_comb begin
    io_rdata_d = 8'h00;
    if (data_hit) begin
      io_rdata_d = rx_empty ? 8'h00 : rx_head;
    end else if (clk_hit) begin
      case (byte_sel)
        2'd0:    io_rdata_d = cnt_q[7:0];
        2'd1:    io_rdata_d = snap_q[15:8];
        2'd2:    io_rdata_d = snap_q[23:16];
        default: io_rdata_d = snap_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q      <= '0;
      snap_q     <= '0;
      done_q     <= 1'b0;
      ibf_q      <= 1'b0;
      io_rdata_q <= 8'h00;
      rd_io_q    <= 1'b1;
    end else begin
      if (!done_q) cnt_q <= cnt_q + 32'd1;
      if (wr && clk_byte0) done_q <= 1'b1;
      ibf_q <= (TX_DEPTH - 32'(tx_count_next)) <= FULL_MARGIN;
      if (rd) begin
        rd_io_q    <= io_sel;
        io_rdata_q <= io_rdata_d;
        if (clk_byte0) snap_q <= cnt_q;
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{mem_a[31:18], snap_q[7:0], tx_full, tx_count, rx_count, rx_count_next};

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: read and TX queues checked by monitors.
module tb_mem_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        program_done;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_rd[$];
  logic [7:0] exp_tx[$];
  logic chk = 1'b0;
  logic chk_q = 1'b0;

  mem_io_responder dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_done   (program_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d,
                     input logic c, input logic [7:0] e);
    mem_a = a; mem_wr = w; mem_dout = d; chk = c;
    if (c) exp_rd.push_back(e);
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus(a, 1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    bus(a, 1'b0, 8'h00, 1'b1, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    mem_a = '0; mem_wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Read-data monitor: a read sampled at an edge is checked on the following low phase.
  always @(posedge clk) chk_q <= rst ? 1'b0 : chk;

  always @(negedge clk) begin
    if (chk_q) begin
      if (exp_rd.size() == 0) check("rd_unexpected", {24'h0, mem_din}, 32'hFFFF_FFFF);
      else check("rd_data", {24'h0, mem_din}, {24'h0, exp_rd.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mem_din", {24'h0, mem_din}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_ibf", {31'h0, io_buffer_full}, 32'h0);
    check("rst_done", {31'h0, program_done}, 32'h0);

    // Counter equals the cycle index since reset; first snapshot read at 0x1FE.
    idle(32'h1FE);
    rd(32'h30004, 8'hFE);
    rd(32'h30005, 8'h01);
    rd(32'h30006, 8'h00);
    rd(32'h30007, 8'h00);
    rd(32'h30004, 8'h02);
    rd(32'h30008, 8'h00);

    wr(32'h00010, 8'hA5);
    rd(32'h00010, 8'hA5);
    wr(32'h00020, 8'h11);
    check("din_hold", {24'h0, mem_din}, 32'hA5);
    wr(32'h1FFFF, 8'h3C);
    rd(32'h1FFFF, 8'h3C);
    rd(32'h00010, 8'hA5);

    tx_ready = 1'b1;
    wr(32'h30000, 8'h48); exp_tx.push_back(8'h48);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h69); exp_tx.push_back(8'h69);
    idle(4);
    check("tx_drained", {31'h0, tx_valid}, 32'h0);

    tx_ready = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      wr(32'h30000, 8'(i)); exp_tx.push_back(8'(i));
    end
    check("ibf_13", {31'h0, io_buffer_full}, 32'h0);
    wr(32'h30000, 8'd14); exp_tx.push_back(8'd14);
    check("ibf_14", {31'h0, io_buffer_full}, 32'h1);
    for (int i = 15; i <= 16; i++) begin
      wr(32'h30000, 8'(i)); exp_tx.push_back(8'(i));
    end
    wr(32'h30000, 8'd17);
    wr(32'h30000, 8'd18);
    check("ibf_full", {31'h0, io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    idle(20);
    check("ibf_cleared", {31'h0, io_buffer_full}, 32'h0);
    check("tx_empty", {31'h0, tx_valid}, 32'h0);

    rx_valid = 1'b1; rx_data = 8'h31; idle(1);
    rx_data = 8'h32; idle(1);
    rx_valid = 1'b0;
    rd(32'h30000, 8'h31);
    rd(32'h30000, 8'h32);
    rd(32'h30000, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h33;
    rd(32'h30000, 8'h00);
    rx_valid = 1'b0;
    rd(32'h30000, 8'h33);

    rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rx_data = 8'h40 + 8'(i);
      idle(1);
    end
    rx_valid = 1'b0;
    check("rx_full", {31'h0, rx_ready}, 32'h0);
    for (int i = 0; i < 16; i++) rd(32'h30000, 8'h40 + 8'(i));
    rd(32'h30000, 8'h00);
    check("rx_ready_again", {31'h0, rx_ready}, 32'h1);

    tx_ready = 1'b0;
    for (int i = 1; i <= 14; i++) wr(32'h30000, 8'h50 + 8'(i));
    wr(32'h30004, 8'h77);
    check("done_set", {31'h0, program_done}, 32'h1);
    check("ibf_before_rst", {31'h0, io_buffer_full}, 32'h1);
    do_reset();
    check("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst2_ibf", {31'h0, io_buffer_full}, 32'h0);
    check("rst2_done", {31'h0, program_done}, 32'h0);
    check("rst2_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst2_mem_din", {24'h0, mem_din}, 32'h0);

    // Stop write in cycle 3 leaves the counter frozen at 4.
    tx_ready = 1'b1;
    idle(3);
    wr(32'h30004, 8'h00); exp_tx.push_back(8'h00);
    check("done_again", {31'h0, program_done}, 32'h1);
    wr(32'h30004, 8'h5A);
    idle(5);
    rd(32'h30004, 8'h04);
    rd(32'h30005, 8'h00);
    rd(32'h00010, 8'hA5);
    idle(3);
    check("tx_idle_end", {31'h0, tx_valid}, 32'h0);
    check("rd_queue_empty", exp_rd.size(), 32'h0);
    check("tx_queue_empty", exp_tx.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
